// File: rtl/m_axi_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : m_axi_cmd_master_if
// Brief    : Command/response and AXI write/read channel bundle for
//            m_axi_cmd_master (master = design side, slave = environment).
// Revision : 1.0
// ============================================================================
interface m_axi_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [3:0]        cmd_wstrb_i;

    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic [1:0]        rsp_resp_o;
    logic              rsp_timeout_o;

    logic [ID_W-1:0]   awid_o;
    logic [ADDR_W-1:0] awaddr_o;
    logic              awvalid_o;
    logic              awready_i;
    logic [DATA_W-1:0] wdata_o;
    logic [3:0]        wstrb_o;
    logic              wvalid_o;
    logic              wready_i;
    logic [ID_W-1:0]   bid_i;
    logic [1:0]        bresp_i;
    logic              bvalid_i;
    logic              bready_o;

    logic [ID_W-1:0]   arid_o;
    logic [ADDR_W-1:0] araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [ID_W-1:0]   rid_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_resp_o, rsp_timeout_o,
        output awid_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        input  awready_i, wready_i, bid_i, bresp_i, bvalid_i,
        output arid_o, araddr_o, arvalid_o, rready_o,
        input  arready_i, rid_i, rdata_i, rresp_i, rvalid_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_resp_o, rsp_timeout_o,
        input  awid_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        output awready_i, wready_i, bid_i, bresp_i, bvalid_i,
        input  arid_o, araddr_o, arvalid_o, rready_o,
        output arready_i, rid_i, rdata_i, rresp_i, rvalid_i
    );
endinterface
`default_nettype wire

// File: rtl/m_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : m_axi_cmd_master
// Brief    : Single-outstanding AXI master turning one command into one AXI
//            write or read, with per-handshake wait timeout.
// Revision : 1.0
// ============================================================================
module m_axi_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TXN_ID  = 0,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              areset,
    m_axi_cmd_master_if.master bus
);

    localparam int               c_cnt_w   = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
    localparam logic [ID_W-1:0]  c_txn_id  = ID_W'(TXN_ID);
    localparam logic [1:0]       c_slverr  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_arvalid;
    logic                r_bready;
    logic                r_rready;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wstrb;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_timeout;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_b_hs;
    logic                w_r_hs;
    logic                w_any_hs;
    logic                w_wait_state;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic                w_timeout;

    // Valid/ready registers are only ever set in their own state, so the
    // handshake terms need no state qualification.
    assign w_aw_hs  = r_awvalid && bus.awready_i;
    assign w_w_hs   = r_wvalid  && bus.wready_i;
    assign w_ar_hs  = r_arvalid && bus.arready_i;
    assign w_b_hs   = r_bready  && bus.bvalid_i;
    assign w_r_hs   = r_rready  && bus.rvalid_i;
    assign w_any_hs = w_aw_hs || w_w_hs || w_ar_hs || w_b_hs || w_r_hs;

    assign w_wait_state = (r_state == S_WR_REQ)  || (r_state == S_WR_RESP) ||
                          (r_state == S_RD_REQ)  || (r_state == S_RD_DATA);

    // Saturating increment: with TIMEOUT=0 the counter parks at its max.
    assign w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == c_timeout);

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.cmd_valid_i && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= bus.cmd_addr_i;
                        r_wdata     <= bus.cmd_wdata_i;
                        r_wstrb     <= bus.cmd_wstrb_i;
                        if (bus.cmd_we_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    // AW and W complete independently; leave once neither is pending.
                    if ((w_aw_hs || !r_awvalid) && (w_w_hs || !r_wvalid)) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_WR_RESP;
                    end else if (w_aw_hs || w_w_hs) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= (bus.bid_i != c_txn_id) ? c_slverr : bus.bresp_i;
                        r_rsp_timeout <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RD_REQ: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RD_DATA;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= bus.rdata_i;
                        r_rsp_resp    <= (bus.rid_i != c_txn_id) ? c_slverr : bus.rresp_i;
                        r_rsp_timeout <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    r_cnt       <= '0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_bready    <= 1'b0;
                    r_rready    <= 1'b0;
                    r_cnt       <= '0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase

            // Abort overrides whatever the wait state scheduled above.
            if (w_wait_state && !w_any_hs && w_timeout) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_bready      <= 1'b0;
                r_rready      <= 1'b0;
                r_cnt         <= '0;
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= c_slverr;
                r_rsp_timeout <= 1'b1;
                r_state       <= S_DONE;
            end
        end
    end

    assign bus.cmd_ready_o   = r_cmd_ready;
    assign bus.awid_o        = c_txn_id;
    assign bus.awaddr_o      = r_addr;
    assign bus.awvalid_o     = r_awvalid;
    assign bus.wdata_o       = r_wdata;
    assign bus.wstrb_o       = r_wstrb;
    assign bus.wvalid_o      = r_wvalid;
    assign bus.bready_o      = r_bready;
    assign bus.arid_o        = c_txn_id;
    assign bus.araddr_o      = r_addr;
    assign bus.arvalid_o     = r_arvalid;
    assign bus.rready_o      = r_rready;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_resp_o    = r_rsp_resp;
    assign bus.rsp_timeout_o = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_m_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_axi_cmd_master
// Brief    : Directed cycle-by-cycle bench for m_axi_cmd_master (TIMEOUT=8,
//            TXN_ID=3); slave side driven on falling edges.
// Revision : 1.0
// ============================================================================
module tb_m_axi_cmd_master;

    localparam int c_txn = 3;

    logic clk;
    logic areset;
    int   n_cmp;
    int   n_err;

    m_axi_cmd_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    m_axi_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .TXN_ID(c_txn), .TIMEOUT(8)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}
    function automatic logic [6:0] ctl();
        return {bus.cmd_ready_o, bus.awvalid_o, bus.wvalid_o, bus.arvalid_o,
                bus.bready_o, bus.rready_o, bus.rsp_valid_o};
    endfunction

    task automatic set_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wdata;
        bus.cmd_wstrb_i = wstrb;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        areset = 1'b1;
        bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_addr_i = '0;
        bus.cmd_wdata_i = '0;   bus.cmd_wstrb_i = '0;
        bus.awready_i = 1'b0; bus.wready_i = 1'b0;
        bus.bid_i = '0; bus.bresp_i = '0; bus.bvalid_i = 1'b0;
        bus.arready_i = 1'b0; bus.rid_i = '0; bus.rdata_i = '0;
        bus.rresp_i = '0; bus.rvalid_i = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_ctl",     ctl(), 7'b1000000);
        chk("rst_rdata",   bus.rsp_rdata_o, 32'h0);
        chk("rst_resp",    bus.rsp_resp_o, 2'b00);
        chk("rst_timeout", bus.rsp_timeout_o, 1'b0);
        chk("rst_payload", {bus.awaddr_o, bus.araddr_o, bus.wdata_o, bus.wstrb_o}, 100'h0);
        areset = 1'b0;

        // Zero-wait write
        tick();
        chk("t1_idle_ctl", ctl(), 7'b1000000);
        set_cmd(1'b1, 32'h1, 32'hC2AAEE2A, 4'hF);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("t1_req_ctl", ctl(), 7'b0110000);
        chk("t1_awaddr",  bus.awaddr_o, 32'h1);
        chk("t1_wdata",   bus.wdata_o, 32'hC2AAEE2A);
        chk("t1_wstrb",   bus.wstrb_o, 4'hF);
        chk("t1_awid",    bus.awid_o, 4'd3);
        bus.awready_i = 1'b1; bus.wready_i = 1'b1;
        tick();
        bus.awready_i = 1'b0; bus.wready_i = 1'b0;
        chk("t1_resp_ctl", ctl(), 7'b0000100);
        bus.bvalid_i = 1'b1; bus.bid_i = 4'd3; bus.bresp_i = 2'b00;
        tick();
        bus.bvalid_i = 1'b0;
        chk("t1_done_ctl", ctl(), 7'b0000001);
        chk("t1_rsp_resp", bus.rsp_resp_o, 2'b00);
        chk("t1_rsp_to",   bus.rsp_timeout_o, 1'b0);
        chk("t1_rsp_data", bus.rsp_rdata_o, 32'h0);
        tick();
        chk("t1_back_idle", ctl(), 7'b1000000);

        // Read with two data wait cycles
        set_cmd(1'b0, 32'h2, 32'h0, 4'h0);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("t3_req_ctl", ctl(), 7'b0001000);
        chk("t3_araddr",  bus.araddr_o, 32'h2);
        chk("t3_arid",    bus.arid_o, 4'd3);
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        chk("t3_wait1_ctl", ctl(), 7'b0000010);
        tick();
        chk("t3_wait2_ctl", ctl(), 7'b0000010);
        tick();
        chk("t3_data_ctl", ctl(), 7'b0000010);
        bus.rvalid_i = 1'b1; bus.rid_i = 4'd3; bus.rdata_i = 32'h7778111A; bus.rresp_i = 2'b00;
        tick();
        bus.rvalid_i = 1'b0;
        chk("t3_done_ctl", ctl(), 7'b0000001);
        chk("t3_rdata",    bus.rsp_rdata_o, 32'h7778111A);
        chk("t3_resp",     bus.rsp_resp_o, 2'b00);
        chk("t3_to",       bus.rsp_timeout_o, 1'b0);
        tick();
        chk("t3_idle_ctl",   ctl(), 7'b1000000);
        chk("t3_rdata_hold", bus.rsp_rdata_o, 32'h7778111A);

        // Write with W accepted 5 cycles after AW
        set_cmd(1'b1, 32'h10, 32'hC2AAEE2A, 4'h3);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("t2_req_ctl", ctl(), 7'b0110000);
        bus.awready_i = 1'b1;
        tick();
        bus.awready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_whold_ctl", ctl(), 7'b0010000);
            chk("t2_whold_data", bus.wdata_o, 32'hC2AAEE2A);
            if (i == 4) bus.wready_i = 1'b1;
            tick();
        end
        bus.wready_i = 1'b0;
        chk("t2_resp_ctl", ctl(), 7'b0000100);
        bus.bvalid_i = 1'b1; bus.bid_i = 4'd3; bus.bresp_i = 2'b00;
        tick();
        bus.bvalid_i = 1'b0;
        chk("t2_done_ctl", ctl(), 7'b0000001);
        chk("t2_rsp_resp", bus.rsp_resp_o, 2'b00);
        chk("t2_rsp_data", bus.rsp_rdata_o, 32'h0);
        tick();
        chk("t2_single_pulse", ctl(), 7'b1000000);

        // Read timeout with arready held low
        set_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_ar_wait_ctl", ctl(), 7'b0001000);
            tick();
        end
        chk("t4_done_ctl", ctl(), 7'b0000001);
        chk("t4_timeout",  bus.rsp_timeout_o, 1'b1);
        chk("t4_resp",     bus.rsp_resp_o, 2'b10);
        chk("t4_rdata",    bus.rsp_rdata_o, 32'h0);
        tick();
        chk("t4_idle_ctl", ctl(), 7'b1000000);
        chk("t4_to_hold",  bus.rsp_timeout_o, 1'b1);

        // Bad BID, then back-to-back command with cmd_valid held high
        set_cmd(1'b1, 32'h5, 32'h12345678, 4'hF);
        tick();
        chk("t5_req_ctl", ctl(), 7'b0110000);
        bus.awready_i = 1'b1; bus.wready_i = 1'b1;
        tick();
        bus.awready_i = 1'b0; bus.wready_i = 1'b0;
        chk("t5_resp_ctl", ctl(), 7'b0000100);
        bus.bvalid_i = 1'b1; bus.bid_i = 4'd4; bus.bresp_i = 2'b00;
        tick();
        bus.bvalid_i = 1'b0;
        chk("t5_done_ctl", ctl(), 7'b0000001);
        chk("t5_slverr",   bus.rsp_resp_o, 2'b10);
        set_cmd(1'b0, 32'h6, 32'h0, 4'h0);
        tick();
        chk("t5_idle_ctl",  ctl(), 7'b1000000);
        chk("t5_resp_hold", bus.rsp_resp_o, 2'b10);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("t5_rd_ctl", ctl(), 7'b0001000);
        chk("t5_araddr", bus.araddr_o, 32'h6);
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        chk("t5_rdata_ctl", ctl(), 7'b0000010);
        bus.rvalid_i = 1'b1; bus.rid_i = 4'd3; bus.rdata_i = 32'hA5A50001; bus.rresp_i = 2'b00;
        tick();
        bus.rvalid_i = 1'b0;
        chk("t5_rd_done", ctl(), 7'b0000001);
        chk("t5_rd_data", bus.rsp_rdata_o, 32'hA5A50001);
        chk("t5_rd_resp", bus.rsp_resp_o, 2'b00);
        tick();

        // Reset during WR_RESP, then read at 0x3
        set_cmd(1'b1, 32'h7, 32'h00000055, 4'h1);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("t6_req_ctl", ctl(), 7'b0110000);
        bus.awready_i = 1'b1; bus.wready_i = 1'b1;
        tick();
        bus.awready_i = 1'b0; bus.wready_i = 1'b0;
        chk("t6_resp_ctl", ctl(), 7'b0000100);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("t6_rst_ctl",   ctl(), 7'b1000000);
        chk("t6_rst_addr",  bus.awaddr_o, 32'h0);
        chk("t6_rst_wdata", bus.wdata_o, 32'h0);
        chk("t6_rst_rdata", bus.rsp_rdata_o, 32'h0);
        tick();
        chk("t6_no_pulse", ctl(), 7'b1000000);
        set_cmd(1'b0, 32'h3, 32'h0, 4'h0);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("t6_rd_ctl", ctl(), 7'b0001000);
        chk("t6_araddr", bus.araddr_o, 32'h3);
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        chk("t6_rdata_ctl", ctl(), 7'b0000010);
        bus.rvalid_i = 1'b1; bus.rid_i = 4'd3; bus.rdata_i = 32'h0BADF00D; bus.rresp_i = 2'b00;
        tick();
        bus.rvalid_i = 1'b0;
        chk("t6_done_ctl", ctl(), 7'b0000001);
        chk("t6_rdata",    bus.rsp_rdata_o, 32'h0BADF00D);
        chk("t6_resp",     bus.rsp_resp_o, 2'b00);
        chk("t6_to",       bus.rsp_timeout_o, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
